// File: rtl/audio_pkg.sv
// Shared types for the audio sample playback path.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 14;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [ADDR_W-1:0]          addr_t;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, RD, HOLD} sfx_state_t;
endpackage

// File: rtl/audio_sfx_player_tick_gen.sv
// Sample-rate tick: one-cycle pulse every CLKS_PER_SAMPLE cycles while enabled.
// Dropping enable for a cycle returns the count to zero.
module sample_tick_gen #(
  parameter int CLKS_PER_SAMPLE = 1134
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic enable,
  output logic tick
);
  localparam int            CW   = $clog2(CLKS_PER_SAMPLE);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SAMPLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (enable && cnt_q != LAST) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = enable & (cnt_q == LAST);
endmodule

// File: rtl/audio_sfx_player.sv
// Walks the sample RAM at the sample rate and hands each sample to the
// codec serializer over valid/ready; silence and address 0 when idle.
module audio_sfx_player
  import audio_pkg::*;
#(
  parameter int SFX_LEN         = 8958,
  parameter int CLKS_PER_SAMPLE = 1134
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       play,
  input  logic                       stop,
  input  logic                       loop,
  output logic [ADDR_W-1:0]          read_address,
  input  logic [SAMPLE_W-1:0]        ram_data,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);
  localparam addr_t LAST_ADDR = addr_t'(SFX_LEN - 1);

  sfx_state_t state_q, state_d;
  addr_t      addr_q, addr_d;
  sample_t    sample_q, sample_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       pend_q, pend_d;
  logic       tick, clr_cnt, hs;

  // Gating enable for one cycle is how a restart zeroes the tick counter.
  sample_tick_gen #(.CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)) u_tick (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .enable ((state_q != IDLE) && !clr_cnt),
    .tick   (tick)
  );

  assign hs = valid_q & sample_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    pend_d   = pend_q;
    clr_cnt  = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      addr_d   = '0;
      sample_d = '0;
      valid_d  = 1'b0;
      pend_d   = 1'b0;
      clr_cnt  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (play) begin
          state_d = WAIT_TICK;
          ovr_d   = 1'b0;
        end
        WAIT_TICK, RD: begin
          if (play) begin
            state_d = WAIT_TICK;
            addr_d  = '0;
            clr_cnt = 1'b1;
            ovr_d   = 1'b0;
          end else if (state_q == RD) begin
            sample_d = sample_t'(ram_data);
            valid_d  = 1'b1;
            state_d  = HOLD;
          end else if (tick) begin
            state_d = RD;
          end
        end
        HOLD: begin
          if (play) begin
            pend_d = 1'b1;
            ovr_d  = 1'b0;
          end
          // The held sample is never dropped; a late tick is only flagged.
          if (tick) ovr_d = 1'b1;
          if (hs) begin
            valid_d = 1'b0;
            state_d = WAIT_TICK;
            if (pend_q || play) begin
              addr_d = '0;
              pend_d = 1'b0;
            end else if (addr_q == LAST_ADDR) begin
              addr_d = '0;
              if (!loop) begin
                state_d  = IDLE;
                sample_d = '0;
                done_d   = 1'b1;
              end
            end else begin
              addr_d = addr_q + addr_t'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      pend_q   <= pend_d;
    end
  end

  assign read_address = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_audio_sfx_player.sv
// Directed bench for audio_sfx_player with a 4-sample effect at 8 clocks/sample.
module tb_audio_sfx_player;
  localparam int LEN = 4;
  localparam int CPS = 8;

  logic        Clk = 1'b0;
  logic        Reset_n, play, stop, loop, sample_ready;
  logic [13:0] read_address;
  logic [15:0] ram_data;
  logic signed [15:0] sample_out;
  logic        sample_valid, busy, done, overrun;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int d0, n;
  logic [15:0] mem [16];
  logic [15:0] lexp [10];

  typedef struct {
    int          cyc;
    logic        v;
    logic [15:0] s;
    logic        b;
    logic        d;
    logic [13:0] a;
  } vec_t;
  vec_t tbl [11];

  always #5 Clk = ~Clk;
  always @(posedge Clk) ram_data <= mem[read_address[3:0]];
  always @(negedge Clk) if (done === 1'b1) done_cnt++;

  audio_sfx_player #(.SFX_LEN(LEN), .CLKS_PER_SAMPLE(CPS)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .play(play), .stop(stop), .loop(loop),
    .read_address(read_address), .ram_data(ram_data), .sample_out(sample_out),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .busy(busy),
    .done(done), .overrun(overrun)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sample_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk({name, "_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic pulse_play();
    play = 1'b1;
    step();
    play = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
    mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033; mem[3] = 16'h0044;
    lexp = '{16'h11, 16'h22, 16'h33, 16'h44, 16'h11, 16'h22, 16'h33, 16'h44, 16'h11, 16'h22};
    // cycle offsets relative to the play cycle (cycle 0)
    tbl[0]  = '{0,  1'b0, 16'h0000, 1'b0, 1'b0, 14'd0};
    tbl[1]  = '{1,  1'b0, 16'h0000, 1'b1, 1'b0, 14'd0};
    tbl[2]  = '{9,  1'b0, 16'h0000, 1'b1, 1'b0, 14'd0};
    tbl[3]  = '{10, 1'b1, 16'h0011, 1'b1, 1'b0, 14'd0};
    tbl[4]  = '{11, 1'b0, 16'h0011, 1'b1, 1'b0, 14'd1};
    tbl[5]  = '{17, 1'b0, 16'h0011, 1'b1, 1'b0, 14'd1};
    tbl[6]  = '{18, 1'b1, 16'h0022, 1'b1, 1'b0, 14'd1};
    tbl[7]  = '{26, 1'b1, 16'h0033, 1'b1, 1'b0, 14'd2};
    tbl[8]  = '{34, 1'b1, 16'h0044, 1'b1, 1'b0, 14'd3};
    tbl[9]  = '{35, 1'b0, 16'h0000, 1'b0, 1'b1, 14'd0};
    tbl[10] = '{36, 1'b0, 16'h0000, 1'b0, 1'b0, 14'd0};

    Reset_n = 1'b0; play = 1'b0; stop = 1'b0; loop = 1'b0; sample_ready = 1'b1;
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_sample", {16'd0, $unsigned(sample_out)}, 32'd0);
    chk("rst_addr", {18'd0, read_address}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    Reset_n = 1'b1;
    repeat (2) step();

    // one-shot playback, table of checkpoints
    d0 = done_cnt;
    for (int c = 0; c <= 40; c++) begin
      for (int k = 0; k < 11; k++) begin
        if (tbl[k].cyc == c) begin
          chk($sformatf("c%0d_valid", c), {31'd0, sample_valid}, {31'd0, tbl[k].v});
          chk($sformatf("c%0d_sample", c), {16'd0, $unsigned(sample_out)}, {16'd0, tbl[k].s});
          chk($sformatf("c%0d_busy", c), {31'd0, busy}, {31'd0, tbl[k].b});
          chk($sformatf("c%0d_done", c), {31'd0, done}, {31'd0, tbl[k].d});
          chk($sformatf("c%0d_addr", c), {18'd0, read_address}, {18'd0, tbl[k].a});
        end
      end
      play = (c == 0);
      step();
    end
    play = 1'b0;
    chk("oneshot_done_pulses", done_cnt - d0, 32'd1);
    chk("oneshot_overrun", {31'd0, overrun}, 32'd0);

    // looping playback
    loop = 1'b1;
    d0 = done_cnt;
    pulse_play();
    n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      if (sample_valid && sample_ready) begin
        chk($sformatf("loop_s%0d", n), {16'd0, $unsigned(sample_out)}, {16'd0, lexp[n]});
        n++;
      end
      step();
    end
    chk("loop_count", n, 32'd10);
    chk("loop_busy", {31'd0, busy}, 32'd1);
    chk("loop_no_done", done_cnt - d0, 32'd0);
    loop = 1'b0;
    do_stop();

    // backpressure and overrun
    sample_ready = 1'b0;
    pulse_play();
    wait_valid("ovr_first");
    chk("ovr_first", {16'd0, $unsigned(sample_out)}, 32'h11);
    repeat (20) step();
    chk("ovr_held_sample", {16'd0, $unsigned(sample_out)}, 32'h11);
    chk("ovr_held_valid", {31'd0, sample_valid}, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    sample_ready = 1'b1;
    step();
    wait_valid("ovr_next");
    chk("ovr_next_sample", {16'd0, $unsigned(sample_out)}, 32'h22);
    chk("ovr_next_addr", {18'd0, read_address}, 32'd1);
    pulse_play();
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);
    chk("ovr_restart_addr", {18'd0, read_address}, 32'd0);
    do_stop();

    // restart while holding 0x33
    sample_ready = 1'b0;
    d0 = done_cnt;
    pulse_play();
    for (int k = 0; k < 4; k++) begin
      wait_valid("rs_walk");
      if (sample_out == 16'sh0033) break;
      sample_ready = 1'b1;
      step();
      sample_ready = 1'b0;
    end
    chk("rs_reached_33", {16'd0, $unsigned(sample_out)}, 32'h33);
    pulse_play();
    chk("rs_held_valid", {31'd0, sample_valid}, 32'd1);
    chk("rs_held_sample", {16'd0, $unsigned(sample_out)}, 32'h33);
    sample_ready = 1'b1;
    step();
    wait_valid("rs_next");
    chk("rs_next_sample", {16'd0, $unsigned(sample_out)}, 32'h11);
    chk("rs_next_addr", {18'd0, read_address}, 32'd0);
    chk("rs_no_done", done_cnt - d0, 32'd0);
    do_stop();

    // stop and play together while holding a sample
    sample_ready = 1'b0;
    pulse_play();
    wait_valid("sp_wait");
    d0 = done_cnt;
    stop = 1'b1; play = 1'b1;
    step();
    stop = 1'b0; play = 1'b0;
    chk("sp_busy", {31'd0, busy}, 32'd0);
    chk("sp_valid", {31'd0, sample_valid}, 32'd0);
    chk("sp_sample", {16'd0, $unsigned(sample_out)}, 32'd0);
    chk("sp_addr", {18'd0, read_address}, 32'd0);
    step();
    chk("sp_no_done", done_cnt - d0, 32'd0);

    // asynchronous reset in HOLD
    pulse_play();
    wait_valid("ar_wait");
    #2 Reset_n = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_valid", {31'd0, sample_valid}, 32'd0);
    chk("ar_sample", {16'd0, $unsigned(sample_out)}, 32'd0);
    chk("ar_addr", {18'd0, read_address}, 32'd0);
    chk("ar_overrun", {31'd0, overrun}, 32'd0);
    step();
    Reset_n = 1'b1;
    step();
    sample_ready = 1'b1;
    pulse_play();
    wait_valid("ar_replay");
    chk("ar_replay_sample", {16'd0, $unsigned(sample_out)}, 32'h11);
    chk("ar_replay_addr", {18'd0, read_address}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/audio_sfx_player.md
Name: audio_sfx_player

Overview:
- Playback sequencer that sits directly downstream of the 16-bit audio sample RAM (14-bit address, synchronous read, 1-cycle latency).
- On a play request it walks RAM addresses 0..SFX_LEN-1, one sample per sample-rate tick.
- Each fetched sample goes to the codec serializer over a valid/ready handshake.
- When idle it drives silence, and it signals completion so game logic can chain or loop effects.

Parameters:
- SFX_LEN, 8958: number of samples in the effect; last address is SFX_LEN-1; legal range 1..16384.
- CLKS_PER_SAMPLE, 1134: Clk cycles per sample tick (50 MHz / 44.1 kHz, rounded); minimum 4.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- play  in  1  single-cycle request to start, or restart, the effect from address 0.
- stop  in  1  single-cycle request to abort playback.
- loop  in  1  level; when high, wrap to address 0 after the last sample instead of finishing.
- read_address  out  14  RAM read address.
- ram_data  in  16  RAM data_Out, valid one cycle after read_address.
- sample_out  out  16  signed PCM sample to serializer.
- sample_valid  out  1  sample_out holds a new sample.
- sample_ready  in  1  serializer accepts; transfer occurs when valid && ready on a rising edge.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a non-looping effect completes.
- overrun  out  1  sticky flag: a tick arrived while a sample was still unaccepted; cleared by play.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE, read_address=0, sample_out=0, sample_valid=0, busy=0, done=0, overrun=0, tick counter=0, pending-restart=0.
- Tick generator:
  - Counts 0..CLKS_PER_SAMPLE-1 only while busy, and is held at 0 in IDLE.
  - tick is high for one cycle when count==CLKS_PER_SAMPLE-1.
  - The first tick after play occurs CLKS_PER_SAMPLE cycles after the play cycle.
- States:
  - IDLE: sample_out=0, read_address=0. play -> WAIT_TICK and clear overrun.
  - WAIT_TICK: read_address holds the current address. tick -> RD.
  - RD: exactly one cycle, so ram_data is guaranteed to reflect read_address. At the edge ending RD: sample_out<=ram_data, sample_valid<=1, state -> HOLD.
  - HOLD: sample_valid=1 and sample_out stays stable until the handshake. On handshake: sample_valid<=0, then
    - if address==SFX_LEN-1 and loop=0: address<=0, done pulses in the following cycle, sample_out<=0, state -> IDLE;
    - if address==SFX_LEN-1 and loop=1: address<=0, state -> WAIT_TICK;
    - else: address<=address+1, state -> WAIT_TICK.
- Latency: sample_valid rises 2 cycles after the tick cycle.
- Handshake rule: sample_valid never drops without a handshake, except on stop or reset.
- Overrun:
  - A tick while in HOLD sets overrun.
  - The sample is held rather than dropped, and no fetch is skipped.
  - The tick counter keeps running.
- play while busy:
  - In WAIT_TICK or RD: address<=0, tick counter<=0, state -> WAIT_TICK. An in-flight RD capture is discarded.
  - In HOLD: pending-restart<=1. On the handshake, address<=0 and state -> WAIT_TICK, overriding the end/loop logic, and done is suppressed.
- stop: from any state -> IDLE the next cycle, sample_valid<=0, sample_out<=0, address<=0, no done pulse. This is an abort and is the only legal valid-drop.
- Simultaneous play and stop: stop wins.
- Simultaneous play and handshake in HOLD: the restart is applied; that handshake still transfers the held sample.
- SFX_LEN=1: every handshake hits the end condition.
- Address arithmetic: 14-bit unsigned; the end comparison uses SFX_LEN-1 sized to 14 bits; no natural wrap is relied on.

Decomposition:
- Package audio_pkg:
  - SAMPLE_W=16, ADDR_W=14;
  - sample_t (logic signed [15:0]), addr_t (logic [13:0]);
  - enum sfx_state_t {IDLE, WAIT_TICK, RD, HOLD}.
- One sub-module, sample_tick_gen: parameter CLKS_PER_SAMPLE, inputs Clk, Reset_n, enable; output tick.

Test Plan:
- SFX_LEN=4, CLKS_PER_SAMPLE=8, RAM preloaded with 0x0011, 0x0022, 0x0033, 0x0044, sample_ready tied 1, pulse play -> samples 0x0011..0x0044 handshake exactly 8 cycles apart; first valid 10 cycles after play; done pulses once; busy falls; sample_out returns to 0.
- Same setup with loop=1 for 10 ticks -> sequence 11,22,33,44,11,22,33,44,11,22; no done pulse; busy stays 1.
- sample_ready held 0 for 20 cycles on the first sample -> sample_out stays 0x0011 with valid high; overrun=1; on release the next sample is 0x0022, not skipped; the next play clears overrun.
- play pulsed while HOLD holds 0x0033 (ready=0), then ready=1 -> 0x0033 transfers, next sample is 0x0011, no done pulse.
- stop and play asserted together mid-playback -> IDLE next cycle, valid=0, sample_out=0, address=0, done=0.
- Reset_n asserted low mid-HOLD, asynchronously between edges -> all outputs at reset values immediately; after release, play restarts cleanly from address 0.
